imem_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the single-cycle core's word-addressed instruction memory. It owns the program counter, issues one read per cycle to a synchronous-read instruction memory, and buffers returned words in a 2-entry queue. It delivers `{inst, inst_pc}` to decode over a valid/ready handshake, and handles PC redirects from branch/jump resolution plus address faults.

---
 rtl/imem_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one synchronous-read per cycle,
// buffers returned words in a 2-entry queue and hands them to decode over valid/ready.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   localparam logic [31:0] LAST_PC = 32'(4 * IMEM_WORDS - 4);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic              pend_q, pend_d;
   logic [31:0]       pend_pc_q, pend_pc_d;
   logic [1:0][31:0]  q_data_q, q_data_d;
   logic [1:0][31:0]  q_pc_q, q_pc_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              fault_q, fault_d;
   logic [31:0]       fault_pc_q, fault_pc_d;

   logic              q_nonempty;
   logic              pop;
   logic              q_pop;
   logic              push;
   logic              issue_ok;
   logic              in_range;
   logic              flush;
   logic [1:0]        occupancy;

   // A response arriving into an empty queue is presented directly, so a word is
   // visible on inst in the same cycle it leaves the memory.
   always_comb begin
      q_nonempty = (count_q != 2'd0);
      inst_valid = (q_nonempty | pend_q) & (state_q != FAULT);
      inst       = '0;
      inst_pc    = '0;
      if (q_nonempty) begin
         inst    = q_data_q[rd_ptr_q];
         inst_pc = q_pc_q[rd_ptr_q];
      end else if (pend_q) begin
         inst    = imem_rdata;
         inst_pc = pend_pc_q;
      end
      pop       = inst_valid & inst_ready;
      q_pop     = pop & q_nonempty;
      push      = pend_q & ~(pop & ~q_nonempty);
      occupancy = count_q + {1'b0, pend_q};
      issue_ok  = (state_q == RUN) & ~redirect_valid & (occupancy < 2'd2);
      in_range  = (fetch_pc_q <= LAST_PC);
      imem_en   = issue_ok & in_range;
      imem_addr = {fetch_pc_q[31:2], 2'b00};
      fault     = fault_q;
      fault_pc  = fault_pc_q;
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_d     = imem_en;
      pend_pc_d  = pend_pc_q;
      q_data_d   = q_data_q;
      q_pc_d     = q_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q + {1'b0, push} - {1'b0, q_pop};
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      flush      = 1'b0;

      if (q_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
         q_data_d[wr_ptr_q] = imem_rdata;
         q_pc_d[wr_ptr_q]   = pend_pc_q;
         wr_ptr_d           = ~wr_ptr_q;
      end
      if (imem_en) begin
         pend_pc_d  = imem_addr;
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      case (state_q)
         IDLE:    state_d = RUN;
         RUN: begin
            if (issue_ok & ~in_range) begin
               state_d    = FAULT;
               fault_d    = 1'b1;
               fault_pc_d = fetch_pc_q;
               flush      = 1'b1;
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase

      // Redirect wins over everything, including a fault raised in the same cycle.
      if (redirect_valid) begin
         flush      = 1'b1;
         fetch_pc_d = redirect_pc;
         if (redirect_pc[1:0] != 2'b00) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
         end else begin
            state_d = RUN;
            fault_d = 1'b0;
         end
      end

      if (flush) begin
         pend_d   = 1'b0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         pend_q     <= 1'b0;
         pend_pc_q  <= '0;
         q_data_q   <= '0;
         q_pc_q     <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         q_data_q   <= q_data_d;
         q_pc_q     <= q_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed cycle-by-cycle stimulus, with delivered
// instructions checked against an expected-order scoreboard by a separate monitor.
module tb_imem_fetch_ctrl;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fault;
   logic [31:0] fault_pc;

   logic        rst2_n;
   logic        imem_en2;
   logic [31:0] imem_addr2;
   logic [31:0] imem_rdata2 = '0;
   logic        inst_valid2;
   logic        inst_ready2 = 1'b1;
   logic [31:0] inst2;
   logic [31:0] inst_pc2;
   logic        redirect_valid2 = 1'b0;
   logic [31:0] redirect_pc2 = '0;
   logic        fault2;
   logic [31:0] fault_pc2;
   logic        bad_read2 = 1'b0;

   int          vectors_applied = 0;
   int          miscompares = 0;
   exp_t        exp_q[$];
   exp_t        exp2_q[$];

   always #5 clk = ~clk;

   imem_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .fault(fault), .fault_pc(fault_pc)
   );

   imem_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_small (
      .clk(clk), .rst_n(rst2_n), .imem_en(imem_en2), .imem_addr(imem_addr2),
      .imem_rdata(imem_rdata2), .inst_valid(inst_valid2), .inst_ready(inst_ready2),
      .inst(inst2), .inst_pc(inst_pc2), .redirect_valid(redirect_valid2),
      .redirect_pc(redirect_pc2), .fault(fault2), .fault_pc(fault_pc2)
   );

   // ROM contents: word k holds A000_0000 + k.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= 32'hA000_0000 + (imem_addr >> 2);
      if (imem_en2) imem_rdata2 <= 32'hA000_0000 + (imem_addr2 >> 2);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      vectors_applied++;
      if (actual !== required) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      inst_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL unexpected_delivery: actual pc=%h required none", inst_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("deliver_pc", inst_pc, e.pc);
            checkOutput("deliver_inst", inst, e.data);
         end
      end
   end

   always @(negedge clk) begin
      if (rst2_n === 1'b1 && imem_en2 === 1'b1 && imem_addr2 >= 32'd16) bad_read2 = 1'b1;
      if (rst2_n === 1'b1 && inst_valid2 === 1'b1 && inst_ready2 === 1'b1) begin
         if (exp2_q.size() == 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL small_unexpected_delivery: actual pc=%h required none", inst_pc2);
         end else begin
            exp_t e;
            e = exp2_q.pop_front();
            checkOutput("small_deliver_pc", inst_pc2, e.pc);
            checkOutput("small_deliver_inst", inst2, e.data);
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      rst2_n         = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      exp_q.push_back('{32'h00, 32'hA000_0000});
      exp_q.push_back('{32'h04, 32'hA000_0001});
      exp_q.push_back('{32'h08, 32'hA000_0002});
      exp_q.push_back('{32'h0C, 32'hA000_0003});
      exp_q.push_back('{32'h10, 32'hA000_0004});
      exp_q.push_back('{32'h40, 32'hA000_0010});
      exp_q.push_back('{32'h44, 32'hA000_0011});
      exp_q.push_back('{32'h00, 32'hA000_0000});
      exp_q.push_back('{32'h04, 32'hA000_0001});
      exp_q.push_back('{32'h08, 32'hA000_0002});
      exp_q.push_back('{32'h00, 32'hA000_0000});
      exp_q.push_back('{32'h04, 32'hA000_0001});
      exp2_q.push_back('{32'h00, 32'hA000_0000});
      exp2_q.push_back('{32'h04, 32'hA000_0001});
      exp2_q.push_back('{32'h08, 32'hA000_0002});
      exp2_q.push_back('{32'h0C, 32'hA000_0003});

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_imem_en", {31'b0, imem_en}, 32'd0);
      checkOutput("rst_imem_addr", imem_addr, 32'h0);
      checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("rst_inst", inst, 32'h0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);
      checkOutput("rst_fault", {31'b0, fault}, 32'd0);
      checkOutput("rst_fault_pc", fault_pc, 32'h0);

      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      rst2_n = 1'b1;

      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("c1_imem_en", {31'b0, imem_en}, 32'd1);
      checkOutput("c1_imem_addr", imem_addr, 32'h0);
      checkOutput("c1_inst_valid", {31'b0, inst_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("c2_inst_valid", {31'b0, inst_valid}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0);

      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("bp_imem_en_c5", {31'b0, imem_en}, 32'd0);
      checkOutput("small_no_oob_issue", {31'b0, imem_en2}, 32'd0);
      checkOutput("small_fault_c5", {31'b0, fault2}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("small_fault_c6", {31'b0, fault2}, 32'd1);
      checkOutput("small_fault_pc", fault_pc2, 32'h10);
      checkOutput("small_inst_valid", {31'b0, inst_valid2}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("bp_held_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("bp_held_pc", inst_pc, 32'h8);
      checkOutput("bp_imem_en_c8", {31'b0, imem_en}, 32'd0);

      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("release_imem_en_c9", {31'b0, imem_en}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("resume_imem_en", {31'b0, imem_en}, 32'd1);
      checkOutput("resume_imem_addr", imem_addr, 32'h10);
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);

      applyStimulus(1'b0, 1'b1, 32'h40);
      checkOutput("pre_redirect_head", inst_pc, 32'h14);
      checkOutput("redirect_cycle_en", {31'b0, imem_en}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("redir_n1_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("redir_n1_imem_en", {31'b0, imem_en}, 32'd1);
      checkOutput("redir_n1_addr", imem_addr, 32'h40);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("redir_n2_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("redir_n2_pc", inst_pc, 32'h40);
      applyStimulus(1'b1, 1'b0, 32'h0);

      applyStimulus(1'b0, 1'b1, 32'h42);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("misalign_fault", {31'b0, fault}, 32'd1);
      checkOutput("misalign_fault_pc", fault_pc, 32'h42);
      checkOutput("misalign_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("misalign_imem_en", {31'b0, imem_en}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h0);
      checkOutput("fault_held", {31'b0, fault}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("recover_fault", {31'b0, fault}, 32'd0);
      checkOutput("recover_imem_en", {31'b0, imem_en}, 32'd1);
      checkOutput("recover_addr", imem_addr, 32'h0);
      repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("inflight_imem_en", {31'b0, imem_en}, 32'd1);

      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_imem_en", {31'b0, imem_en}, 32'd0);
      checkOutput("midrst_imem_addr", imem_addr, 32'h0);
      checkOutput("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("midrst_inst", inst, 32'h0);
      checkOutput("midrst_inst_pc", inst_pc, 32'h0);
      checkOutput("midrst_fault", {31'b0, fault}, 32'd0);
      checkOutput("midrst_fault_pc", fault_pc, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("rerun_c1_en", {31'b0, imem_en}, 32'd1);
      checkOutput("rerun_c1_valid", {31'b0, inst_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("rerun_c2_pc", inst_pc, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);

      checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
      checkOutput("small_scoreboard_drained", exp2_q.size(), 32'd0);
      checkOutput("small_no_oob_read", {31'b0, bad_read2}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
